// File: rtl/pixel_fetch_unit.sv
// Pixel fetch unit: walks an IMG_W x IMG_H frame of 8-bit pixels in raster order from a
// synchronous-read memory and streams them on a valid/ready interface with row/frame markers.
module pixel_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_eol,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;

    logic              inflight;
    logic              inflight_eol;
    logic              inflight_last;

    logic [7:0]        buf_data [2];
    logic [1:0]        buf_eol;
    logic [1:0]        buf_last;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic              pop;
    logic              push;
    logic              issue;
    logic              tag_eol;
    logic              tag_last;
    logic [2:0]        credit_use;

    // A read returns data in the cycle after it is issued, so the in-flight flag
    // doubles as the buffer write strobe.
    assign pop        = pix_valid & pix_ready;
    assign push       = inflight;
    assign credit_use = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue      = (state == S_FETCH) && (credit_use < 3'd2);
    assign tag_eol    = (col == COL_MAX);
    assign tag_last   = tag_eol && (row == ROW_MAX);

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)                          state_nxt = S_FETCH;
            S_FETCH: if (issue && tag_last)              state_nxt = S_DRAIN;
            S_DRAIN: if ((count == 2'd0) && !inflight)   state_nxt = S_DONE;
            default:                                     state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            addr  <= '0;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && start) begin
                addr <= base_addr;
                col  <= '0;
                row  <= '0;
            end else if (issue) begin
                addr <= addr + ADDR_W'(1);
                if (tag_eol) begin
                    col <= '0;
                    row <= row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight      <= 1'b0;
            inflight_eol  <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_eol  <= tag_eol;
                inflight_last <= tag_last;
            end
        end
    end

    // NOTE: the two buffer entries are reset too, so pix_data reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_eol     <= '0;
            buf_last    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= mem_rdata;
                buf_eol[wr_ptr]  <= inflight_eol;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign mem_rd_en = issue;
    assign mem_addr  = addr;
    assign pix_valid = (count != 2'd0);
    assign pix_data  = buf_data[rd_ptr];
    assign pix_eol   = pix_valid & buf_eol[rd_ptr];
    assign pix_last  = pix_valid & buf_last[rd_ptr];
    assign busy      = (state == S_FETCH) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

endmodule
